// File: rtl/bridge_mailbox_pkg.sv
// bridge_mailbox_pkg: bridge bus types, mailbox register offsets and bit positions
package bridge_mailbox_pkg;
  typedef logic [31:0] bridge_addr_t;
  typedef logic [31:0] bridge_data_t;
  localparam logic [3:0] MBOX_RX_DATA = 4'h0;
  localparam logic [3:0] MBOX_TX_DATA = 4'h4;
  localparam logic [3:0] MBOX_STATUS  = 4'h8;
  localparam logic [3:0] MBOX_CTRL    = 4'hC;
  localparam int ST_RX_FULL     = 0;
  localparam int ST_RX_EMPTY    = 1;
  localparam int ST_TX_FULL     = 2;
  localparam int ST_TX_EMPTY    = 3;
  localparam int ST_RX_OVERFLOW = 4;
  localparam int ST_TX_UNDERFLOW = 5;
  localparam int CTRL_RX_FLUSH  = 0;
  localparam int CTRL_TX_FLUSH  = 1;
  localparam int CTRL_CLR_STICKY = 2;
endpackage

// File: rtl/bridge_if.sv
// bridge_if: host bridge bus; leaf modport drives only rd_data
interface bridge_if import bridge_mailbox_pkg::*; (input logic clk);
  bridge_addr_t addr;
  bridge_data_t wr_data;
  bridge_data_t rd_data;
  logic wr;
  logic rd;
  modport leaf (input addr, input wr_data, input wr, input rd, output rd_data);
  modport host (input clk, output addr, output wr_data, output wr, output rd, input rd_data);
endinterface

// File: rtl/bridge_mailbox_fifo.sv
// bridge_mailbox_fifo: show-ahead FIFO with flush; head reads 0 while empty
module bridge_mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];
  // pointer and occupancy bookkeeping; flush wins over any transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: empty gates the head to 0
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/bridge_mailbox.sv
// bridge_mailbox: bridge leaf exposing an RX and a TX word FIFO to the host
module bridge_mailbox import bridge_mailbox_pkg::*; #(
  parameter bridge_addr_t BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  bridge_if.leaf      bridge,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic sel, unused;
  logic [3:0] off;
  logic rx_push, rx_full, rx_empty, rx_flush;
  logic tx_pop, tx_full, tx_empty, tx_flush;
  logic ctrl_wr, clr_sticky, rx_overflow, tx_underflow;
  logic [CW-1:0] rx_count, tx_count;
  logic [31:0] tx_head, status;
  assign unused     = ^bridge.addr[1:0];
  assign sel        = bridge.addr[31:4] == BASE_ADDR[31:4];
  assign off        = {bridge.addr[3:2], 2'b00};
  assign rx_push    = bridge.wr && sel && off == MBOX_RX_DATA;
  assign tx_pop     = bridge.rd && sel && off == MBOX_TX_DATA;
  assign ctrl_wr    = bridge.wr && sel && off == MBOX_CTRL;
  assign rx_flush   = ctrl_wr && bridge.wr_data[CTRL_RX_FLUSH];
  assign tx_flush   = ctrl_wr && bridge.wr_data[CTRL_TX_FLUSH];
  assign clr_sticky = ctrl_wr && bridge.wr_data[CTRL_CLR_STICKY];
  assign rx_valid   = !rx_empty;
  assign tx_ready   = !tx_full;
  bridge_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx (
    .clk, .reset_n, .flush(rx_flush), .push(rx_push), .wdata(bridge.wr_data),
    .pop(rx_ready), .rdata(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  bridge_mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx (
    .clk, .reset_n, .flush(tx_flush), .push(tx_valid), .wdata(tx_data),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  // STATUS word from pre-edge FIFO state and sticky flags
  always_comb begin
    status = '0;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_OVERFLOW]  = rx_overflow;
    status[ST_TX_UNDERFLOW] = tx_underflow;
    status[15:8]            = 8'(rx_count);
    status[23:16]           = 8'(tx_count);
  end
  // sticky error flags and registered read port, held between rd pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overflow    <= 1'b0;
      tx_underflow   <= 1'b0;
      bridge.rd_data <= '0;
    end else begin
      if (clr_sticky) rx_overflow <= 1'b0;
      else if (rx_push && rx_full) rx_overflow <= 1'b1;
      if (clr_sticky) tx_underflow <= 1'b0;
      else if (tx_pop && tx_empty) tx_underflow <= 1'b1;
      if (bridge.rd)
        bridge.rd_data <= !sel ? '0 : off == MBOX_TX_DATA ? tx_head : off == MBOX_STATUS ? status : '0;
    end
  end
endmodule

// File: tb/tb_bridge_mailbox.sv
// tb_bridge_mailbox: directed plus randomized checks against a queue-based mailbox model
module tb_bridge_mailbox;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0001_2340;
  logic clk = 0, reset_n = 0;
  logic [31:0] rx_data, tx_data;
  logic rx_valid, rx_ready, tx_valid, tx_ready;
  int errors = 0, checks = 0;
  logic [31:0] rxq[$], txq[$];
  logic m_ovf, m_unf;
  logic [31:0] m_rd;
  always #5 clk = ~clk;
  bridge_if bus (.clk(clk));
  bridge_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bridge(bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_status();
    return {8'h0, 8'(txq.size()), 8'(rxq.size()), 2'b0, m_unf, m_ovf,
            txq.size() == 0, txq.size() == DEPTH, rxq.size() == 0, rxq.size() == DEPTH};
  endfunction
  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rd = 0;
  endtask
  // one cycle: compare outputs, drive op (0 idle, 1 wr, 2 rd), advance model to post-edge state
  task automatic cyc(input int op, input logic [31:0] a, input logic [31:0] d,
                     input logic rr, input logic tv, input logic [31:0] td);
    logic sel;
    logic [1:0] r;
    int rxn, txn;
    check("rx_valid", rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("rx_data", rx_data, rxq[0]);
    check("tx_ready", tx_ready, txq.size() < DEPTH);
    check("rd_data", bus.rd_data, m_rd);
    bus.wr = op == 1;
    bus.rd = op == 2;
    bus.addr = a;
    bus.wr_data = d;
    rx_ready = rr;
    tx_valid = tv;
    tx_data = td;
    sel = a[31:4] == BASE[31:4];
    r = a[3:2];
    rxn = rxq.size();
    txn = txq.size();
    if (op == 2) m_rd = !sel ? 0 : r == 1 ? (txn != 0 ? txq[0] : 0) : r == 2 ? m_status() : 0;
    if (op == 1 && sel && r == 3 && d[0]) rxq.delete();
    else begin
      if (rr && rxn != 0) void'(rxq.pop_front());
      if (op == 1 && sel && r == 0) begin
        if (rxn == DEPTH) m_ovf = 1;
        else rxq.push_back(d);
      end
    end
    if (op == 1 && sel && r == 3 && d[1]) txq.delete();
    else begin
      if (op == 2 && sel && r == 1) begin
        if (txn == 0) m_unf = 1;
        else void'(txq.pop_front());
      end
      if (tv && txn < DEPTH) txq.push_back(td);
    end
    if (op == 1 && sel && r == 3 && d[2]) begin
      m_ovf = 0;
      m_unf = 0;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic read_status();
    cyc(2, BASE + 8, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset_n = 0;
    bus.wr = 0;
    bus.rd = 0;
    rx_ready = 0;
    tx_valid = 0;
    #2;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rd_data", bus.rd_data, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    bus.addr = 0;
    bus.wr_data = 0;
    bus.wr = 0;
    bus.rd = 0;
    rx_ready = 0;
    tx_valid = 0;
    tx_data = 0;
    @(negedge clk);
    do_reset();
    read_status();
    check("status_reset", bus.rd_data, 32'h0000_000A);
    cyc(1, BASE, 32'h11, 0, 0, 0);
    cyc(1, BASE + 1, 32'h22, 0, 0, 0);
    cyc(1, BASE, 32'h33, 0, 0, 0);
    read_status();
    check("rx_count3", bus.rd_data[15:8], 3);
    check("rx_head", rx_data, 32'h11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    check("rx_drained", rx_valid, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, i);
    check("tx_full_ready", tx_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(2, BASE + 4, 0, 0, 0, 0);
      check("tx_order", bus.rd_data, i);
    end
    cyc(2, BASE + 4, 0, 0, 0, 0);
    check("tx_underflow_data", bus.rd_data, 0);
    read_status();
    check("unf_set", bus.rd_data[5], 1);
    cyc(1, BASE + 12, 4, 0, 0, 0);
    read_status();
    check("unf_clr", bus.rd_data[5], 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, BASE, 32'h100 + i, 0, 0, 0);
    cyc(1, BASE, 32'hDEAD, 1, 0, 0);
    read_status();
    check("ovf_count", bus.rd_data[15:8], 15);
    check("ovf_set", bus.rd_data[4], 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0, 0);
    check("ovf_drained", rx_valid, 0);
    read_status();
    cyc(2, BASE + 32'h10, 0, 0, 0, 0);
    check("unsel_rd", bus.rd_data, 0);
    cyc(1, BASE + 32'h10, 32'h55, 0, 0, 0);
    check("unsel_wr", rx_valid, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'hA0 + i);
    cyc(1, BASE + 12, 2, 0, 1, 32'h99);
    read_status();
    check("tx_flush_cnt", bus.rd_data[23:16], 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 32'hB0 + i);
    cyc(2, BASE + 4, 0, 0, 1, 32'hC0);
    read_status();
    check("pushpop_cnt", bus.rd_data[23:16], 8);
    cyc(1, BASE + 12, 7, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int op, pick;
      logic [31:0] a, d;
      logic rr, tv;
      if (i == 2000) do_reset();
      pick = $urandom_range(0, 99);
      op = pick < 40 ? 0 : pick < 70 ? 1 : 2;
      a = BASE + {$urandom_range(0, 3), 2'(0)} + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      d = $urandom;
      if (op == 1 && a[3:2] == 3 && $urandom_range(0, 3) != 0) d = 0;
      rr = $urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 20);
      tv = $urandom_range(0, 99) < ((i / 500) % 2 ? 20 : 70);
      cyc(op, a, d, rr, tv, $urandom);
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
